axis_packet_arbiter: RTL and testbench
======================================

# axis_packet_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream datapath, typically the input of the data-width downsizer, among NUM_PORTS requesting streams. A grant is held from the first beat of a packet through its tlast beat, so packets from different ports are never interleaved. The index of the granted port is driven on m_axis_tid so downstream logic can route or tag the packet. A per-port enable mask lets software exclude ports without disturbing a packet already in flight.

## Interface
- NUM_PORTS, 4: number of slave streams; 2..16.
- DATA_WIDTH, 64: tdata width; multiple of 8.
- ID_WIDTH, $clog2(NUM_PORTS): width of m_axis_tid.
- TUSER_WIDTH, 1: tuser width per port; tuser is muxed alongside tdata.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset_n  in  1  reset, asynchronous, active-low.
- port_en  in  NUM_PORTS  arbitration enable mask; bit i = 0 excludes port i from new grants.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  port i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8].
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tuser  in  NUM_PORTS*TUSER_WIDTH  per-port user.
- m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1/TUSER_WIDTH  shared output stream.
- m_axis_tid  out  ID_WIDTH  index of granted port.
- busy  out  1  high while in BUSY.
- grant_idx  out  ID_WIDTH  current or last grant, for debug.

## Operation
- States: IDLE, BUSY. Registers: state, grant (ID_WIDTH), last_grant (ID_WIDTH).
- Reset: state=IDLE, grant=0, last_grant=NUM_PORTS-1, so port 0 has first priority.
- IDLE: request vector req = s_axis_tvalid & port_en. If req != 0, the next cycle has grant = first set bit of req searched cyclically from last_grant+1, and state=BUSY. If req == 0, the block stays in IDLE.
- IDLE outputs: m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata/tkeep/tlast/tuser=0, m_axis_tid=grant.
- BUSY outputs, combinational pass-through from port g=grant: m_axis_tvalid=s_axis_tvalid[g], m_axis_tdata/tkeep/tlast/tuser = port g slices, m_axis_tid=g.
- BUSY ready: s_axis_tready[g]=m_axis_tready; all other ready bits are 0.
- BUSY exit: on a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast, the next cycle has state=IDLE and last_grant=g.
- In BUSY, deassertion of s_axis_tvalid[g] only stalls the output; the grant is held until tlast.
- port_en changes affect only arbitration decisions in IDLE. Clearing port_en[g] while in BUSY does not abort the packet in flight.
- A port with tvalid high but port_en low never receives tready.
- busy = (state==BUSY). grant_idx = grant.

## Timing
- Arbitration latency is 1 cycle: a request seen in an IDLE cycle is granted and its first beat is presentable in the following cycle.
- The minimum inter-packet gap is 1 idle cycle after each tlast handshake.
- A single-beat packet (tlast on the first beat) occupies exactly 1 BUSY cycle if m_axis_tready is high.
- Combinational paths: m_axis_tready -> s_axis_tready[g], and s_axis_tvalid[g] -> m_axis_tvalid. No combinational path exists from any input to the grant decision except through registers.
- Fairness: with all enabled ports continuously requesting, the grant order is 0,1,..,NUM_PORTS-1,0,...; each port waits at most NUM_PORTS-1 packets.
- Asynchronous reset mid-packet: all outputs drop to 0 immediately, the state returns to IDLE and the partial packet is abandoned. Upstream must be reset together with this block.

## Test plan
- Reset/idle: assert areset_n=0 mid-packet, then release with no tvalid -> m_axis_tvalid=0, s_axis_tready=4'b0000, busy=0, and the first later grant goes to port 0.
- Round-robin: ports 0-3 each send continuous 3-beat packets with m_axis_tready=1 -> m_axis_tid sequence 0,1,2,3,0; each packet is 3 contiguous beats followed by exactly 1 idle cycle.
- No interleave: port 1 sends 4 beats with tvalid gaps while port 2 requests -> all 4 port-1 beats complete before any port-2 beat; s_axis_tready[2]=0 throughout.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 2-beat packet from port 3 -> s_axis_tready[3] mirrors m_axis_tready and data 0xAA..,0xBB.. emerge in order with no loss or duplication.
- Mask: port_en=4'b1101 with all ports requesting -> port 1 is never granted and its tready stays 0. Clearing port_en[2] during port 2's packet -> that packet still completes through tlast.
- Single-beat packets: port 0 sends tlast on every beat while others are idle -> each beat is followed by 1 idle cycle and m_axis_tid stays 0.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream output among
// NUM_PORTS input streams. A grant is held from the first beat to tlast,
// so packets are never interleaved. The granted index appears on m_axis_tid.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | no grant; output quiet, arbitrating over tvalid & port_en
//  ST_BUSY | port `grant` owns the output until its tlast handshake
module axis_packet_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = $clog2(NUM_PORTS),
  parameter int TUSER_WIDTH = 1
) (
  input  logic                              aclk,
  input  logic                              areset_n,
  input  logic [NUM_PORTS-1:0]              port_en,
  input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
  output logic [NUM_PORTS-1:0]              s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]              s_axis_tlast,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]  s_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic [ID_WIDTH-1:0]               m_axis_tid,
  output logic                              busy,
  output logic [ID_WIDTH-1:0]               grant_idx
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [ID_WIDTH-1:0] grant, grant_d;
  logic [ID_WIDTH-1:0] last_grant, last_grant_d;
  logic [ID_WIDTH-1:0] rr_pick;
  logic                req_any;
  logic [NUM_PORTS-1:0] req;

  assign req = s_axis_tvalid & port_en;

  // Cyclic search from last_grant+1; descending so the nearest requester wins.
  always_comb begin
    int idx;
    rr_pick = last_grant;
    req_any = 1'b0;
    idx     = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_PORTS;
      if (req[idx]) begin
        rr_pick = ID_WIDTH'(idx);
        req_any = 1'b1;
      end
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
    end
  end

  // Next-state decision and combinational pass-through from the granted port.
  always_comb begin
    state_d       = state;
    grant_d       = grant;
    last_grant_d  = last_grant;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    m_axis_tid    = grant;
    s_axis_tready = '0;

    if (state == ST_BUSY) begin
      m_axis_tvalid        = s_axis_tvalid[grant];
      m_axis_tdata         = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep         = s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tlast         = s_axis_tlast[grant];
      m_axis_tuser         = s_axis_tuser[int'(grant)*TUSER_WIDTH +: TUSER_WIDTH];
      s_axis_tready[grant] = m_axis_tready;
    end

    case (state)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_BUSY;
          grant_d = rr_pick;
        end
      end
      ST_BUSY: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d      = ST_IDLE;
          last_grant_d = grant;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_BUSY);
  assign grant_idx = grant;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench for axis_packet_arbiter with a transaction-level model:
// per-port packet queues, an owner/pointer pair and the round-robin rule.
module tb_axis_packet_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int IW = 2;
  localparam int UW = 1;

  logic              aclk = 1'b0;
  logic              areset_n;
  logic [NP-1:0]     port_en;
  logic [NP-1:0]     s_tvalid, s_tready, s_tlast;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP*UW-1:0]  s_tuser;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic [IW-1:0]     m_tid, grant_idx;
  logic              busy;

  axis_packet_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TUSER_WIDTH(UW)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .port_en(port_en),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_axis_tid(m_tid), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t q [NP][$];
  int    tid_hist[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_busy;
  int    m_grant;
  int    m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_grant = 0;
    m_last  = NP - 1;
    for (int i = 0; i < NP; i++) q[i].delete();
  endtask

  task automatic load(input int port, input int npkt, input int minlen, input int maxlen);
    for (int p = 0; p < npkt; p++) begin
      int len;
      len = int'($urandom_range(maxlen, minlen));
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        bt.data = {$urandom, $urandom};
        bt.keep = KW'($urandom);
        bt.user = UW'($urandom);
        bt.last = (b == len - 1);
        q[port].push_back(bt);
      end
    end
  endtask

  // Present each port's head beat; tvalid forced or random when data is pending.
  task automatic drive(input bit force_v, input bit rdy_always);
    for (int i = 0; i < NP; i++) begin
      if (q[i].size() > 0) begin
        s_tvalid[i]             = force_v || ($urandom_range(3, 0) != 0);
        s_tdata[i*DW +: DW]     = q[i][0].data;
        s_tkeep[i*KW +: KW]     = q[i][0].keep;
        s_tlast[i]              = q[i][0].last;
        s_tuser[i*UW +: UW]     = q[i][0].user;
      end else begin
        s_tvalid[i]             = 1'b0;
        s_tdata[i*DW +: DW]     = '0;
        s_tkeep[i*KW +: KW]     = '0;
        s_tlast[i]              = 1'b0;
        s_tuser[i*UW +: UW]     = '0;
      end
    end
    m_tready = rdy_always || ($urandom_range(2, 0) != 0);
  endtask

  // Compare this cycle's outputs with the model, then advance one clock.
  task automatic step();
    #1;
    if (!m_busy) begin
      logic [NP-1:0] req;
      bit found;
      check("idle_tvalid", 64'(m_tvalid), 64'(0));
      check("idle_tready", 64'(s_tready), 64'(0));
      check("idle_tdata", m_tdata, 64'(0));
      check("idle_tkeep", 64'(m_tkeep), 64'(0));
      check("idle_tlast", 64'(m_tlast), 64'(0));
      check("idle_tid", 64'(m_tid), 64'(m_grant));
      check("idle_busy", 64'(busy), 64'(0));
      req   = s_tvalid & port_en;
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (!found && req[p]) begin
          found   = 1'b1;
          m_grant = p;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        tid_hist.push_back(m_grant);
      end
    end else begin
      int g;
      g = m_grant;
      check("busy", 64'(busy), 64'(1));
      check("tid", 64'(m_tid), 64'(g));
      check("grant_idx", 64'(grant_idx), 64'(g));
      check("tvalid", 64'(m_tvalid), 64'(s_tvalid[g]));
      check("tready", 64'(s_tready), m_tready ? (64'(1) << g) : 64'(0));
      if (s_tvalid[g]) begin
        check("tdata", m_tdata, q[g][0].data);
        check("tkeep", 64'(m_tkeep), 64'(q[g][0].keep));
        check("tlast", 64'(m_tlast), 64'(q[g][0].last));
        check("tuser", 64'(m_tuser), 64'(q[g][0].user));
        if (m_tready) begin
          if (q[g][0].last) begin
            m_busy = 1'b0;
            m_last = g;
          end
          void'(q[g].pop_front());
        end
      end
    end
    @(posedge aclk);
    #1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic random_phase(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (c % 40 == 0)
        port_en = ($urandom_range(2, 0) == 0) ? NP'($urandom) : '1;
      drive(1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    areset_n = 1'b0;
    port_en  = '1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_grant", 64'(grant_idx), 64'(0));
    areset_n = 1'b1;

    // Round robin: two 3-beat packets per port, all continuously valid.
    for (int i = 0; i < NP; i++) load(i, 2, 3, 3);
    tid_hist.delete();
    for (int c = 0; c < 80 && !(all_empty() && !m_busy); c++) begin
      drive(1'b1, 1'b1);
      step();
    end
    for (int i = 0; i < 5; i++)
      check("rr_order", 64'(i < tid_hist.size() ? tid_hist[i] : 99), 64'(i % NP));

    // Single-beat packets from port 0 only.
    load(0, 5, 1, 1);
    tid_hist.delete();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1);
      step();
    end
    check("single_cnt", 64'(tid_hist.size()), 64'(5));
    foreach (tid_hist[i]) check("single_tid", 64'(tid_hist[i]), 64'(0));

    // Randomized traffic, masks and backpressure.
    for (int i = 0; i < NP; i++) load(i, 30, 1, 4);
    random_phase(1500);

    // Reset in the middle of a packet.
    port_en = '1;
    if (all_empty()) load(2, 2, 3, 4);
    for (int c = 0; c < 200 && !m_busy; c++) begin
      drive(1'b1, 1'b0);
      step();
    end
    check("pre_rst_busy", 64'(busy), 64'(1));
    drive(1'b1, 1'b1);
    #2;
    areset_n = 1'b0;
    #1;
    check("async_rst_tvalid", 64'(m_tvalid), 64'(0));
    check("async_rst_tready", 64'(s_tready), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_tid", 64'(m_tid), 64'(0));
    @(posedge aclk);
    #1;
    model_reset();
    drive(1'b0, 1'b0);
    areset_n = 1'b1;
    step();

    // First grant after reset must go to port 0.
    for (int i = 0; i < NP; i++) load(i, 20, 1, 4);
    tid_hist.delete();
    drive(1'b1, 1'b1);
    step();
    check("first_grant", 64'(tid_hist.size() > 0 ? tid_hist[0] : 99), 64'(0));
    random_phase(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
